// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC fetch sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NPC_HOLD  = 2'd0,
    NPC_INC   = 2'd1,
    NPC_REDIR = 2'd2
  } npc_sel_t;

  localparam logic [63:0] DEF_RESET_VEC = 64'h0;
  localparam logic [63:0] DEF_INC       = 64'h4;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return (lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_adder.sv
// Sequential next-PC adder; wraps modulo 2^WIDTH, carry discarded.
module pc_next_adder #(
  parameter int unsigned       WIDTH = 64,
  parameter logic [WIDTH-1:0]  INC   = WIDTH'(4)
) (
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = pc_i + INC;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register plus instruction-fetch handshake FSM with pending-redirect latch.
// Optional feature macro: PC_SEQ_MISALIGN_EN (rejects redirect targets with [1:0]!=0).
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] INC       = WIDTH'(DEF_INC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_valid,
  output logic             misalign
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic             pc_valid_q, pc_valid_d;
  logic             misalign_q, misalign_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] pc_inc_s;
  logic [WIDTH-1:0] redir_tgt_s;
  npc_sel_t         npc_sel_s;
  logic             bad_s;
  logic             redir_s;

  pc_next_adder #(.WIDTH(WIDTH), .INC(INC)) u_adder (
    .pc_i  (pc_q),
    .sum_o (pc_inc_s)
  );

`ifdef PC_SEQ_MISALIGN_EN
  assign bad_s = redirect_valid & is_misaligned(redirect_target[1:0]);
`else
  assign bad_s = 1'b0;
`endif
  assign redir_s = redirect_valid & ~bad_s;

  // Next-state, next-PC selection and output next values.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    pc_out_d    = pc_out_q;
    pc_valid_d  = 1'b0;
    misalign_d  = bad_s;
    npc_sel_s   = NPC_HOLD;
    redir_tgt_s = redirect_target;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redir_s) npc_sel_s = NPC_REDIR;
        else         npc_sel_s = NPC_HOLD;
      end
      REQ: begin
        if (imem_ack) begin
          // A pending or same-cycle redirect squashes the fetch that just landed.
          if (redir_s || pend_q) begin
            npc_sel_s = NPC_REDIR;
            if (redir_s) redir_tgt_s = redirect_target;
            else         redir_tgt_s = pend_tgt_q;
            pend_d  = 1'b0;
            state_d = REQ;
          end else begin
            npc_sel_s  = NPC_INC;
            pc_valid_d = 1'b1;
            pc_out_d   = pc_q;
            if (stall) state_d = HOLD;
            else       state_d = REQ;
          end
        end else begin
          state_d = REQ;
          if (redir_s) begin
            pend_d     = 1'b1;
            pend_tgt_d = redirect_target;
          end else begin
            pend_d     = pend_q;
          end
        end
      end
      HOLD: begin
        if (stall) state_d = HOLD;
        else       state_d = REQ;
        if (redir_s) npc_sel_s = NPC_REDIR;
        else         npc_sel_s = NPC_HOLD;
      end
      default: state_d = IDLE;
    endcase
    case (npc_sel_s)
      NPC_INC:   pc_d = pc_inc_s;
      NPC_REDIR: pc_d = redir_tgt_s;
      default:   pc_d = pc_q;
    endcase
    req_d = (state_d == REQ);
  end

  // State, PC, pending redirect and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_tgt_q <= RESET_VEC;
      pc_out_q   <= RESET_VEC;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      pc_out_q   <= pc_out_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
      req_q      <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc_out    = pc_out_q;
  assign pc_valid  = pc_valid_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed + randomized bench for pc_fetch_sequencer against a transaction-level model.
module tb_pc_fetch_sequencer;

  localparam logic [63:0] RV  = 64'h0;
  localparam logic [63:0] INC = 64'h4;
`ifdef PC_SEQ_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = 64'h0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [63:0] pc_out;
  logic        pc_valid;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  // Reference model: "fetching" means a request is outstanding, "parked" means stalled after delivery.
  bit          m_fetching, m_parked, m_pend, m_valid, m_mis;
  logic [63:0] m_pc, m_pend_tgt, m_pc_out;

  pc_fetch_sequencer #(.WIDTH(64), .RESET_VEC(RV), .INC(INC)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .pc_out(pc_out), .pc_valid(pc_valid), .misalign(misalign)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit bad, take;
    if (reset) begin
      m_fetching = 0; m_parked = 0; m_pend = 0; m_valid = 0; m_mis = 0;
      m_pc = RV; m_pend_tgt = RV; m_pc_out = RV;
      return;
    end
    bad     = MIS_EN && redirect_valid && (redirect_target[1:0] != 2'b00);
    take    = redirect_valid && !bad;
    m_mis   = bad;
    m_valid = 0;
    if (m_fetching) begin
      if (imem_ack) begin
        if (take || m_pend) begin
          m_pc   = take ? redirect_target : m_pend_tgt;
          m_pend = 0;
        end else begin
          m_valid    = 1;
          m_pc_out   = m_pc;
          m_pc       = m_pc + INC;
          m_fetching = !stall;
          m_parked   = stall;
        end
      end else if (take) begin
        m_pend     = 1;
        m_pend_tgt = redirect_target;
      end
    end else begin
      if (take) m_pc = redirect_target;
      if (!(m_parked && stall)) begin
        m_fetching = 1;
        m_parked   = 0;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
    chk("imem_req",  {63'd0, imem_req}, {63'd0, m_fetching});
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_valid",  {63'd0, pc_valid}, {63'd0, m_valid});
    chk("pc_out",    pc_out, m_pc_out);
    chk("misalign",  {63'd0, misalign}, {63'd0, m_mis});
  endtask

  initial begin
    // 1: reset, then ack tied high -> 0,4,8,C delivered on consecutive cycles
    reset = 1'b1;
    repeat (3) cyc();
    chk("reset_req", {63'd0, imem_req}, 64'd0);
    chk("reset_addr", imem_addr, 64'h0);
    reset = 1'b0; imem_ack = 1'b1;
    cyc();
    chk("first_req", {63'd0, imem_req}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("seq_pc_out", pc_out, 64'(4 * i));
      chk("seq_valid", {63'd0, pc_valid}, 64'd1);
    end
    // 2: ack held off three cycles at 0x10
    imem_ack = 1'b0;
    repeat (3) begin
      cyc();
      chk("wait_addr", imem_addr, 64'h10);
    end
    imem_ack = 1'b1;
    cyc();
    chk("late_pc_out", pc_out, 64'h10);
    chk("late_next", imem_addr, 64'h14);
    // 3: redirect while waiting at 0x20 squashes that fetch
    repeat (3) cyc();
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h100;
    cyc();
    chk("redir_addr_held", imem_addr, 64'h20);
    redirect_valid = 1'b0;
    cyc();
    imem_ack = 1'b1;
    cyc();
    chk("squash_valid", {63'd0, pc_valid}, 64'd0);
    chk("redir_addr", imem_addr, 64'h100);
    // 4: stall at 0x30
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h30;
    cyc();
    redirect_valid = 1'b0; imem_ack = 1'b1;
    cyc();
    stall = 1'b1;
    cyc();
    chk("stall_pc_out", pc_out, 64'h30);
    imem_ack = 1'b0;
    repeat (2) begin
      cyc();
      chk("stall_req", {63'd0, imem_req}, 64'd0);
    end
    stall = 1'b0;
    cyc();
    chk("unstall_addr", imem_addr, 64'h34);
    // 5: wrap at 2^64-4, then reset mid-wait
    redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    redirect_valid = 1'b0; imem_ack = 1'b1;
    cyc();
    cyc();
    chk("wrap_addr", imem_addr, 64'h0);
    imem_ack = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    chk("midreset_req", {63'd0, imem_req}, 64'd0);
    chk("midreset_addr", imem_addr, RV);
    reset = 1'b0; imem_ack = 1'b1;
    repeat (3) cyc();
    // 6: misaligned redirect target
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h102;
    cyc();
    redirect_valid = 1'b0; imem_ack = 1'b1;
    cyc();
`ifdef PC_SEQ_MISALIGN_EN
    chk("mis_addr", imem_addr, 64'hC);
`else
    chk("mis_addr", imem_addr, 64'h102);
`endif
    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 63) == 0);
      imem_ack       = ($urandom_range(0, 2) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_target = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
